mem_wb_stage_buffer: RTL and testbench
======================================

MEM_WB_STAGE_BUFFER -- requirements
Module: mem_wb_stage_buffer

Parameters
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the width of the ALU result and memory data paths.
REQ-002 The block SHALL have parameter REG_W, default 5, giving the width of the destination register index.
REQ-003 The block SHALL have parameter ZERO_SUPPRESS, default 1; when 1, a write to register index 0 is presented with RegWriteOut=0.

Interface
REQ-004 Clock  in  1  single clock; all state SHALL update on the rising edge only.
REQ-005 Reset_n  in  1  synchronous, active-low reset.
REQ-006 InValid  in  1  the MEM stage presents a bundle.
REQ-007 InReady  out  1  the buffer accepts a bundle this cycle; SHALL be a registered output.
REQ-008 MemToRegIn, RegWriteIn  in  1 each  MEM-stage control bits.
REQ-009 WriteRegisterIn  in  REG_W  destination register index.
REQ-010 ALUResultIn, DataMemoryIn  in  DATA_W each  MEM-stage data.
REQ-011 Flush  in  1  discards all held bundles.
REQ-012 OutValid  out  1  the head bundle is valid; OutReady  in  1  the WB stage consumes the head.
REQ-013 MemToRegOut, RegWriteOut  out  1 each; WriteRegisterOut  out  REG_W; ALUResultOut, DataMemoryOut  out  DATA_W each  head bundle fields.
REQ-014 WriteDataOut  out  DATA_W  write-back value: DataMemoryOut if MemToRegOut=1, else ALUResultOut.
REQ-015 Occupancy  out  2  number of held bundles (0..2).

Function
REQ-016 The block SHALL be a 2-entry skid buffer: a head register (drives outputs) and a skid register, with states EMPTY (0), ONE (1) and FULL (2).
REQ-017 An accept SHALL occur when InValid=1 and InReady=1; a pop SHALL occur when OutValid=1 and OutReady=1.
REQ-018 EMPTY + accept -> ONE, with the bundle in the head and visible on the outputs the next cycle (latency 1).
REQ-019 ONE + accept + pop -> ONE, with the head replaced by the new bundle (throughput 1 per cycle).
REQ-020 ONE + accept without pop -> FULL, with the new bundle held in the skid register.
REQ-021 ONE + pop without accept -> EMPTY.
REQ-022 FULL + pop -> ONE, with the skid bundle moved to the head; no accept is possible in FULL.
REQ-023 InReady SHALL be 1 in EMPTY and ONE, and 0 in FULL, as registered from the next-state value.
REQ-024 OutValid SHALL be 1 exactly in states ONE and FULL.
REQ-025 When OutValid=0, RegWriteOut SHALL be 0; the other data outputs are don't-care but SHALL hold their last value.
REQ-026 When ZERO_SUPPRESS=1 and WriteRegisterOut=0, RegWriteOut SHALL be 0.
REQ-027 Bundles SHALL leave the buffer in arrival order, and no bundle SHALL be dropped or duplicated except by Flush or reset.
REQ-028 Flush=1 SHALL move the buffer to EMPTY at the next edge with InReady=1, discarding all held bundles and any same-cycle accept or pop.
REQ-029 When OutValid=1 and OutReady=0, all head outputs SHALL hold stable.
REQ-030 WriteDataOut and RegWriteOut SHALL be combinational from head state only, with no path from any input.

Reset
REQ-031 While Reset_n=0 at a rising edge, the block SHALL go to EMPTY and set OutValid=0, InReady=1, Occupancy=0, RegWriteOut=0 and MemToRegOut=0.
REQ-032 On that same edge, WriteRegisterOut, ALUResultOut, DataMemoryOut and the skid register SHALL be set to 0.
REQ-033 Reset SHALL take priority over Flush and over any handshake, and a reset applied mid-stream SHALL discard all held bundles.

Verification
REQ-034 Streaming: OutReady=1, bundles with ALUResultIn=0x10,0x20,0x30, RegWriteIn=1, WriteRegisterIn=3 on consecutive cycles -> outputs 0x10,0x20,0x30 one cycle later, back-to-back, with Occupancy=1 throughout.
REQ-035 Backpressure: OutReady=0, accept A=0x11 and B=0x22 -> Occupancy=2 and InReady=0; then OutReady=1 -> A, then B, with InReady=1 one cycle after A pops.
REQ-036 Writeback mux: MemToRegIn=1, DataMemoryIn=0xDEADBEEF, ALUResultIn=0x4 -> WriteDataOut=0xDEADBEEF; MemToRegIn=0 -> WriteDataOut=0x4.
REQ-037 Zero register: RegWriteIn=1 with WriteRegisterIn=0 -> RegWriteOut=0 while OutValid=1; with WriteRegisterIn=7 -> RegWriteOut=1.
REQ-038 Flush: in FULL, Flush=1 together with InValid=1 -> next cycle EMPTY, OutValid=0, InReady=1, and the incoming bundle is never output.
REQ-039 Reset mid-stream: in FULL, Reset_n=0 for one edge -> all outputs at reset values; after release, the first accepted bundle 0x55 is output alone.

Source files
------------

// File: rtl/mem_wb_stage_buffer.sv
// MEM/WB pipeline register built as a 2-entry skid buffer with a valid/ready handshake on both sides.
// The head entry drives the outputs; the skid entry catches one bundle while the WB stage stalls.
module mem_wb_stage_buffer #(
   parameter int          DATA_W        = 32,
   parameter int          REG_W         = 5,
   parameter int unsigned ZERO_SUPPRESS = 1
) (
   input  logic              Clock,
   input  logic              Reset_n,
   input  logic              InValid,
   output logic              InReady,
   input  logic              MemToRegIn,
   input  logic              RegWriteIn,
   input  logic [REG_W-1:0]  WriteRegisterIn,
   input  logic [DATA_W-1:0] ALUResultIn,
   input  logic [DATA_W-1:0] DataMemoryIn,
   input  logic              Flush,
   output logic              OutValid,
   input  logic              OutReady,
   output logic              MemToRegOut,
   output logic              RegWriteOut,
   output logic [REG_W-1:0]  WriteRegisterOut,
   output logic [DATA_W-1:0] ALUResultOut,
   output logic [DATA_W-1:0] DataMemoryOut,
   output logic [DATA_W-1:0] WriteDataOut,
   output logic [1:0]        Occupancy
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   typedef struct packed {
      logic              mem_to_reg;
      logic              reg_write;
      logic [REG_W-1:0]  wr_reg;
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] dmem;
   } bundle_t;

   state_t  state_q, state_d;
   bundle_t head_q, head_d;
   bundle_t skid_q, skid_d;
   logic    in_ready_q, in_ready_d;
   bundle_t in_bundle;
   logic    out_valid;
   logic    accept;
   logic    pop;
   logic    zero_dest;

   assign in_bundle = '{mem_to_reg: MemToRegIn,
                        reg_write:  RegWriteIn,
                        wr_reg:     WriteRegisterIn,
                        alu:        ALUResultIn,
                        dmem:       DataMemoryIn};

   assign out_valid = (state_q != EMPTY);
   assign accept    = InValid && in_ready_q;
   assign pop       = out_valid && OutReady;

   // Next-state and data movement; Flush wins over any same-cycle handshake and leaves data untouched.
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      if (Flush) begin
         state_d = EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (accept) begin
                  head_d  = in_bundle;
                  state_d = ONE;
               end
            end
            ONE: begin
               if (accept && pop) begin
                  head_d = in_bundle;
               end else if (accept) begin
                  skid_d  = in_bundle;
                  state_d = FULL;
               end else if (pop) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  head_d  = skid_q;
                  state_d = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
      in_ready_d = (state_d != FULL);
   end

   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         state_q    <= EMPTY;
         in_ready_q <= 1'b1;
         head_q     <= '0;
         skid_q     <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         head_q     <= head_d;
         skid_q     <= skid_d;
      end
   end

   // Outputs depend only on registered head state, never on the current inputs.
   assign zero_dest        = (ZERO_SUPPRESS != 0) && (head_q.wr_reg == '0);
   assign InReady          = in_ready_q;
   assign OutValid         = out_valid;
   assign Occupancy        = state_q;
   assign MemToRegOut      = head_q.mem_to_reg;
   assign RegWriteOut      = out_valid && head_q.reg_write && !zero_dest;
   assign WriteRegisterOut = head_q.wr_reg;
   assign ALUResultOut     = head_q.alu;
   assign DataMemoryOut    = head_q.dmem;
   assign WriteDataOut     = head_q.mem_to_reg ? head_q.dmem : head_q.alu;

endmodule

// File: tb/tb_mem_wb_stage_buffer.sv
// Self-checking bench for mem_wb_stage_buffer: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based reference model.
module tb_mem_wb_stage_buffer;

   typedef struct packed {
      logic        m2r;
      logic        rw;
      logic [4:0]  wr;
      logic [31:0] alu;
      logic [31:0] dmem;
   } bundle_t;

   logic        Clock = 1'b0;
   logic        Reset_n;
   logic        InValid;
   logic        InReady;
   logic        MemToRegIn;
   logic        RegWriteIn;
   logic [4:0]  WriteRegisterIn;
   logic [31:0] ALUResultIn;
   logic [31:0] DataMemoryIn;
   logic        Flush;
   logic        OutValid;
   logic        OutReady;
   logic        MemToRegOut;
   logic        RegWriteOut;
   logic [4:0]  WriteRegisterOut;
   logic [31:0] ALUResultOut;
   logic [31:0] DataMemoryOut;
   logic [31:0] WriteDataOut;
   logic [1:0]  Occupancy;

   int compared   = 0;
   int mismatched = 0;

   bundle_t modelQ[$];
   bundle_t shown;
   logic    modelOk = 1'b0;

   mem_wb_stage_buffer #(.DATA_W(32), .REG_W(5), .ZERO_SUPPRESS(1)) dut (
      .Clock(Clock), .Reset_n(Reset_n), .InValid(InValid), .InReady(InReady),
      .MemToRegIn(MemToRegIn), .RegWriteIn(RegWriteIn), .WriteRegisterIn(WriteRegisterIn),
      .ALUResultIn(ALUResultIn), .DataMemoryIn(DataMemoryIn), .Flush(Flush),
      .OutValid(OutValid), .OutReady(OutReady), .MemToRegOut(MemToRegOut),
      .RegWriteOut(RegWriteOut), .WriteRegisterOut(WriteRegisterOut),
      .ALUResultOut(ALUResultOut), .DataMemoryOut(DataMemoryOut),
      .WriteDataOut(WriteDataOut), .Occupancy(Occupancy)
   );

   always #5 Clock = ~Clock;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a FIFO of at most two bundles; the visible head is the oldest entry,
   // or the last bundle shown once the FIFO drains.
   always @(posedge Clock) begin
      if (!Reset_n) begin
         modelQ.delete();
         shown   = '0;
         modelOk = 1'b1;
      end else if (Flush) begin
         modelQ.delete();
      end else begin
         automatic logic acc = InValid && (modelQ.size() < 2);
         automatic logic pp  = OutReady && (modelQ.size() > 0);
         if (pp) void'(modelQ.pop_front());
         if (acc) modelQ.push_back('{m2r: MemToRegIn, rw: RegWriteIn, wr: WriteRegisterIn,
                                     alu: ALUResultIn, dmem: DataMemoryIn});
      end
      if (modelQ.size() > 0) shown = modelQ[0];
   end

   // Per-cycle comparison of every output against the model, away from the active edge.
   always @(negedge Clock) begin
      if (modelOk) begin
         automatic int n = modelQ.size();
         checkOutput("OutValid", {31'd0, OutValid}, {31'd0, n > 0});
         checkOutput("InReady", {31'd0, InReady}, {31'd0, n < 2});
         checkOutput("Occupancy", {30'd0, Occupancy}, n);
         checkOutput("MemToRegOut", {31'd0, MemToRegOut}, {31'd0, shown.m2r});
         checkOutput("RegWriteOut", {31'd0, RegWriteOut},
                     {31'd0, (n > 0) && shown.rw && (shown.wr != 5'd0)});
         checkOutput("WriteRegisterOut", {27'd0, WriteRegisterOut}, {27'd0, shown.wr});
         checkOutput("ALUResultOut", ALUResultOut, shown.alu);
         checkOutput("DataMemoryOut", DataMemoryOut, shown.dmem);
         checkOutput("WriteDataOut", WriteDataOut, shown.m2r ? shown.dmem : shown.alu);
      end
   end

   task automatic applyStimulus(input logic rstN, input logic flush, input logic inValid,
                                input logic outReady, input logic m2r, input logic rw,
                                input logic [4:0] wr, input logic [31:0] alu,
                                input logic [31:0] dmem);
      Reset_n         = rstN;
      Flush           = flush;
      InValid         = inValid;
      OutReady        = outReady;
      MemToRegIn      = m2r;
      RegWriteIn      = rw;
      WriteRegisterIn = wr;
      ALUResultIn     = alu;
      DataMemoryIn    = dmem;
      @(posedge Clock);
      #1;
   endtask

   task automatic push(input logic outReady, input logic [31:0] alu);
      applyStimulus(1, 0, 1, outReady, 0, 1, 5'd3, alu, 32'h0);
   endtask

   task automatic idle(input logic outReady);
      applyStimulus(1, 0, 0, outReady, 0, 0, 5'd0, 32'h0, 32'h0);
   endtask

   initial begin
      // Reset
      applyStimulus(0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
      applyStimulus(0, 1, 1, 1, 1, 1, 5'd9, 32'hAAAA, 32'hBBBB);
      checkOutput("rst OutValid", {31'd0, OutValid}, 32'd0);
      checkOutput("rst InReady", {31'd0, InReady}, 32'd1);
      checkOutput("rst Occupancy", {30'd0, Occupancy}, 32'd0);
      checkOutput("rst ALUResultOut", ALUResultOut, 32'd0);

      // Streaming at full rate
      push(1, 32'h10);
      checkOutput("stream 0x10", ALUResultOut, 32'h10);
      checkOutput("stream occ", {30'd0, Occupancy}, 32'd1);
      push(1, 32'h20);
      checkOutput("stream 0x20", ALUResultOut, 32'h20);
      push(1, 32'h30);
      checkOutput("stream 0x30", ALUResultOut, 32'h30);
      checkOutput("stream occ end", {30'd0, Occupancy}, 32'd1);
      checkOutput("stream rw", {31'd0, RegWriteOut}, 32'd1);
      idle(1);
      checkOutput("stream drained", {31'd0, OutValid}, 32'd0);

      // Backpressure
      push(0, 32'h11);
      push(0, 32'h22);
      checkOutput("bp occ full", {30'd0, Occupancy}, 32'd2);
      checkOutput("bp inready", {31'd0, InReady}, 32'd0);
      checkOutput("bp head A", ALUResultOut, 32'h11);
      idle(1);
      checkOutput("bp head B", ALUResultOut, 32'h22);
      checkOutput("bp inready back", {31'd0, InReady}, 32'd1);
      idle(1);
      checkOutput("bp empty", {30'd0, Occupancy}, 32'd0);

      // Writeback mux
      applyStimulus(1, 0, 1, 0, 1, 1, 5'd4, 32'h4, 32'hDEADBEEF);
      checkOutput("mux mem", WriteDataOut, 32'hDEADBEEF);
      applyStimulus(1, 0, 1, 1, 0, 1, 5'd4, 32'h4, 32'hDEADBEEF);
      checkOutput("mux alu", WriteDataOut, 32'h4);
      idle(1);

      // Zero register suppression
      applyStimulus(1, 0, 1, 1, 0, 1, 5'd0, 32'h1, 32'h0);
      checkOutput("zero valid", {31'd0, OutValid}, 32'd1);
      checkOutput("zero rw", {31'd0, RegWriteOut}, 32'd0);
      applyStimulus(1, 0, 1, 1, 0, 1, 5'd7, 32'h2, 32'h0);
      checkOutput("r7 rw", {31'd0, RegWriteOut}, 32'd1);
      idle(1);

      // Flush while full, with a competing incoming bundle
      push(0, 32'h61);
      push(0, 32'h62);
      applyStimulus(1, 1, 1, 1, 0, 1, 5'd3, 32'h99, 32'h0);
      checkOutput("flush valid", {31'd0, OutValid}, 32'd0);
      checkOutput("flush inready", {31'd0, InReady}, 32'd1);
      checkOutput("flush occ", {30'd0, Occupancy}, 32'd0);
      idle(1);
      checkOutput("flush no ghost", {31'd0, OutValid}, 32'd0);

      // Reset mid-stream
      push(0, 32'h71);
      push(0, 32'h72);
      applyStimulus(0, 0, 1, 1, 1, 1, 5'd3, 32'h73, 32'h0);
      checkOutput("mrst occ", {30'd0, Occupancy}, 32'd0);
      checkOutput("mrst alu", ALUResultOut, 32'd0);
      checkOutput("mrst m2r", {31'd0, MemToRegOut}, 32'd0);
      checkOutput("mrst wr", {27'd0, WriteRegisterOut}, 32'd0);
      push(1, 32'h55);
      checkOutput("mrst first", ALUResultOut, 32'h55);
      checkOutput("mrst alone", {30'd0, Occupancy}, 32'd1);
      idle(1);
      checkOutput("mrst drained", {31'd0, OutValid}, 32'd0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(($urandom_range(0, 63) != 0), ($urandom_range(0, 15) == 0),
                       ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                       1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
                       $urandom, $urandom);
      end
      idle(1);
      idle(1);

      @(negedge Clock);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
